// File: rtl/bus_pkg.sv
// Bus packet encodings and address types shared by fetch and the
// memory responders.
package bus_pkg;

   typedef enum logic [1:0] {
      read_request  = 2'd0,
      write_request = 2'd1,
      read_response = 2'd2,
      write_ack     = 2'd3
   } bus_packet_t;

   localparam int MEM_ADDR_W = 32;
   typedef logic [MEM_ADDR_W-1:0] memory_address_t;

   localparam int INSN_W = 32;
   typedef logic [INSN_W-1:0] instruction_t;

   // Clears the byte offset inside a 64-bit word.
   localparam memory_address_t ALIGN_MASK = ~memory_address_t'(7);

   function automatic logic is_legal_req(input logic [1:0] t);
      return (t == read_request) || (t == write_request);
   endfunction

endpackage

// File: rtl/insn_mem_responder_mem_word_array.sv
// 64-bit word storage: one combinational read port and one
// byte-enabled synchronous write port.
module mem_word_array #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [7:0]       be,
   input  logic [IDX_W-1:0] waddr,
   input  logic [63:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [63:0]      rdata
);

   logic [63:0] mem [DEPTH];

   // Commit only the enabled bytes of the addressed word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
               mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/insn_mem_responder.sv
// Fixed-latency responder for the fetch memory bus; one request
// outstanding, response held stable until the requester takes it.
module insn_mem_responder
   import bus_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ID_W        = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_data,
   input  logic [7:0]        req_be,
   input  logic [ID_W-1:0]   req_id,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_type,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [63:0]       rsp_data,
   output logic [ID_W-1:0]   rsp_id,
   output logic              rsp_err,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_stall
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(~ALIGN_MASK);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("insn_mem_responder: LATENCY must be 1..15");
   end
   if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("insn_mem_responder: DEPTH_WORDS must be a power of two");
   end

   typedef enum logic [1:0] {
      s_idle,
      s_wait,
      s_resp
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] lat_cnt;
   logic [3:0] lat_cnt_nx;

   logic             accept;
   logic             legal;
   logic             in_rng;
   logic             ok;
   logic             do_rd;
   logic             do_wr;
   logic [IDX_W-1:0] idx;
   logic [63:0]      rd_word;

   assign accept = (state == s_idle) && req_valid;
   assign legal  = is_legal_req(req_type);
   assign in_rng = (req_addr >> (3 + IDX_W)) == '0;
   assign ok     = legal && in_rng;
   assign do_rd  = accept && ok && (req_type == read_request);
   assign do_wr  = accept && ok && (req_type == write_request);
   assign idx    = req_addr[3 +: IDX_W];

   assign req_ready = (state == s_idle);
   assign rsp_valid = (state == s_resp);

   mem_word_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (do_wr),
      .be    (req_be),
      .waddr (idx),
      .wdata (req_data),
      .raddr (idx),
      .rdata (rd_word)
   );

   // State and latency counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= s_idle;
         lat_cnt <= '0;
      end else begin
         state   <= state_nx;
         lat_cnt <= lat_cnt_nx;
      end
   end

   // Next state: accept, count down the latency, hold until taken.
   always_comb begin
      state_nx   = state;
      lat_cnt_nx = lat_cnt;
      unique case (state)
         s_idle: begin
            if (req_valid) begin
               state_nx   = s_wait;
               lat_cnt_nx = 4'(LATENCY - 1);
            end
         end
         s_wait: begin
            if (lat_cnt == '0) begin
               state_nx = s_resp;
            end else begin
               lat_cnt_nx = lat_cnt - 4'd1;
            end
         end
         s_resp: begin
            if (rsp_ready) begin
               state_nx = s_idle;
            end
         end
         default: state_nx = s_idle;
      endcase
   end

   // Response fields are captured at accept and held until the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_type <= '0;
         rsp_addr <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_err  <= 1'b0;
      end else if (accept) begin
         rsp_type <= (legal && req_type == write_request) ?
                     write_ack : read_response;
         rsp_addr <= req_addr & AMASK;
         rsp_data <= do_rd ? rd_word : 64'd0;
         rsp_id   <= req_id;
         rsp_err  <= !ok;
      end
   end

   // Saturating activity counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_stall  <= '0;
      end else begin
         if (do_rd && stat_reads != '1) begin
            stat_reads <= stat_reads + 32'd1;
         end
         if (do_wr && stat_writes != '1) begin
            stat_writes <= stat_writes + 32'd1;
         end
         if (state == s_resp && !rsp_ready && stat_stall != '1) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_insn_mem_responder.sv
// Bench for insn_mem_responder: directed table, reset corner cases
// and randomized traffic against a byte-level memory model.
module tb_insn_mem_responder;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 1024;
   localparam int LAT    = 2;
   localparam int ID_W   = 4;

   logic              clk;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_type;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_data;
   logic [7:0]        req_be;
   logic [ID_W-1:0]   req_id;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_type;
   logic [ADDR_W-1:0] rsp_addr;
   logic [63:0]       rsp_data;
   logic [ID_W-1:0]   rsp_id;
   logic              rsp_err;
   logic [31:0]       stat_reads;
   logic [31:0]       stat_writes;
   logic [31:0]       stat_stall;

   insn_mem_responder #(
      .ADDR_W      (ADDR_W),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .ID_W        (ID_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_type    (req_type),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_be      (req_be),
      .req_id      (req_id),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_type    (rsp_type),
      .rsp_addr    (rsp_addr),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .rsp_err     (rsp_err),
      .stat_reads  (stat_reads),
      .stat_writes (stat_writes),
      .stat_stall  (stat_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_vec = 0;
   int n_err = 0;
   int ref_reads = 0;
   int ref_writes = 0;
   int ref_stall = 0;
   logic [63:0] last_data;
   logic [7:0] mref [int];

   typedef struct {
      logic [1:0]  t;
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  be;
      logic [3:0]  id;
      int          stall;
      logic [1:0]  et;
      logic [31:0] ea;
      logic [63:0] ed;
      logic        ee;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_rsp(input string tag, input logic [1:0] et,
                          input logic [31:0] ea, input logic [63:0] ed,
                          input logic [3:0] eid, input logic ee);
      chk({tag, ".valid"}, 64'(rsp_valid), 64'(1'b1));
      chk({tag, ".type"}, 64'(rsp_type), 64'(et));
      chk({tag, ".addr"}, 64'(rsp_addr), 64'(ea));
      chk({tag, ".data"}, rsp_data, ed);
      chk({tag, ".id"}, 64'(rsp_id), 64'(eid));
      chk({tag, ".err"}, 64'(rsp_err), 64'(ee));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(1'b1));
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1'b0));
      chk({tag, ".rsp_type"}, 64'(rsp_type), 64'(0));
      chk({tag, ".rsp_addr"}, 64'(rsp_addr), 64'(0));
      chk({tag, ".rsp_data"}, rsp_data, 64'(0));
      chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(0));
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(0));
      chk({tag, ".stat_reads"}, 64'(stat_reads), 64'(0));
      chk({tag, ".stat_writes"}, 64'(stat_writes), 64'(0));
      chk({tag, ".stat_stall"}, 64'(stat_stall), 64'(0));
   endtask

   task automatic chk_stats(input string tag);
      chk({tag, ".stat_reads"}, 64'(stat_reads), 64'(ref_reads));
      chk({tag, ".stat_writes"}, 64'(stat_writes), 64'(ref_writes));
      chk({tag, ".stat_stall"}, 64'(stat_stall), 64'(ref_stall));
   endtask

   // Reference: responses from the bus rules, memory as a byte map.
   task automatic model(input logic [1:0] t, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] be,
                        output logic [1:0] et, output logic [31:0] ea,
                        output logic [63:0] ed, output logic ee);
      longint unsigned ua;
      longint unsigned base;
      bit legal;
      bit inr;
      ua    = 64'(a);
      legal = (t == 2'd0) || (t == 2'd1);
      inr   = ua < 64'(DEPTH * 8);
      base  = ua - (ua % 8);
      ea    = 32'(base);
      ee    = !(legal && inr);
      et    = (t == 2'd1) ? 2'd3 : 2'd2;
      ed    = '0;
      if (!ee) begin
         for (int b = 0; b < 8; b++) begin
            int k;
            k = int'(base) + b;
            if (t == 2'd1) begin
               if (be[b]) mref[k] = d[8*b +: 8];
            end else begin
               ed[8*b +: 8] = mref.exists(k) ? mref[k] : 8'h00;
            end
         end
      end
   endtask

   // One transaction; entered and left #1 after a rising edge.
   task automatic run(input string tag, input logic [1:0] t,
                      input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [3:0] id,
                      input int stall, input bit early, input bit junk,
                      input logic [1:0] et, input logic [31:0] ea,
                      input logic [63:0] ed, input logic ee);
      int lat;
      chk({tag, ".ready_idle"}, 64'(req_ready), 64'(1'b1));
      req_valid = 1'b1;
      req_type  = t;
      req_addr  = a;
      req_data  = d;
      req_be    = be;
      req_id    = id;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      if (junk) begin
         req_type = 2'd1;
         req_addr = '0;
         req_data = {$urandom, $urandom};
         req_be   = 8'hFF;
         req_id   = ~id;
      end else begin
         req_valid = 1'b0;
      end
      if (early) rsp_ready = 1'b1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(LAT));
      last_data = rsp_data;
      cmp_rsp(tag, et, ea, ed, id, ee);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         chk({tag, ".stall_ready"}, 64'(req_ready), 64'(1'b0));
         cmp_rsp({tag, ".hold"}, et, ea, ed, id, ee);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk({tag, ".valid_after_hs"}, 64'(rsp_valid), 64'(1'b0));
      if (!ee) begin
         if (et == 2'd2) ref_reads++;
         else ref_writes++;
      end
      ref_stall += stall;
   endtask

   initial begin
      logic [1:0]  t;
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  be;
      logic [3:0]  id;
      int          stall;
      bit          early;
      bit          junk;
      bit          seen;
      logic [1:0]  et;
      logic [31:0] ea;
      logic [63:0] ed;
      logic        ee;

      tbl[0]  = '{2'd1, 32'h10, 64'h1122334455667788, 8'hFF, 4'd1, 0,
                  2'd3, 32'h10, 64'h0, 1'b0};
      tbl[1]  = '{2'd0, 32'h10, 64'h0, 8'h00, 4'd2, 0,
                  2'd2, 32'h10, 64'h1122334455667788, 1'b0};
      tbl[2]  = '{2'd0, 32'h14, 64'h0, 8'h00, 4'd3, 5,
                  2'd2, 32'h10, 64'h1122334455667788, 1'b0};
      tbl[3]  = '{2'd1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 4'd4, 0,
                  2'd3, 32'h10, 64'h0, 1'b0};
      tbl[4]  = '{2'd0, 32'h10, 64'h0, 8'h00, 4'd5, 0,
                  2'd2, 32'h10, 64'h11223344AAAAAAAA, 1'b0};
      tbl[5]  = '{2'd0, 32'h2000, 64'h0, 8'h00, 4'd6, 0,
                  2'd2, 32'h2000, 64'h0, 1'b1};
      tbl[6]  = '{2'd3, 32'h10, 64'h0, 8'hFF, 4'd7, 0,
                  2'd2, 32'h10, 64'h0, 1'b1};
      tbl[7]  = '{2'd1, 32'h2008, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'd8, 0,
                  2'd3, 32'h2008, 64'h0, 1'b1};
      tbl[8]  = '{2'd2, 32'h18, 64'h0, 8'hFF, 4'd9, 0,
                  2'd2, 32'h18, 64'h0, 1'b1};
      tbl[9]  = '{2'd1, 32'h1FF8, 64'h0123456789ABCDEF, 8'hFF, 4'd10, 0,
                  2'd3, 32'h1FF8, 64'h0, 1'b0};
      tbl[10] = '{2'd0, 32'h1FFF, 64'h0, 8'h00, 4'd11, 0,
                  2'd2, 32'h1FF8, 64'h0123456789ABCDEF, 1'b0};
      tbl[11] = '{2'd0, 32'h17, 64'h0, 8'h00, 4'd12, 0,
                  2'd2, 32'h10, 64'h11223344AAAAAAAA, 1'b0};

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_type  = '0;
      req_addr  = '0;
      req_data  = '0;
      req_be    = '0;
      req_id    = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: preload, unaligned read, back-pressure,
      // partial write, out-of-range and illegal types, last word.
      for (int i = 0; i < 12; i++) begin
         run($sformatf("tbl%0d", i), tbl[i].t, tbl[i].a, tbl[i].d,
             tbl[i].be, tbl[i].id, tbl[i].stall, 1'b0, 1'b0,
             tbl[i].et, tbl[i].ea, tbl[i].ed, tbl[i].ee);
         if (i == 2) begin
            chk("slot1", 64'(last_data[63:32]), 64'(32'h11223344));
         end
      end
      chk_stats("tbl_stats");

      // Reset while a write is in WAIT: no response, write kept.
      req_valid = 1'b1;
      req_type  = 2'd1;
      req_addr  = 32'h20;
      req_data  = 64'hDEADBEEFCAFEF00D;
      req_be    = 8'hFF;
      req_id    = 4'd7;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("wait.req_ready", 64'(req_ready), 64'(1'b0));
      reset_n = 1'b0;
      #1;
      chk_reset_vals("rst_wait");
      @(posedge clk);
      #1;
      reset_n    = 1'b1;
      ref_reads  = 0;
      ref_writes = 0;
      ref_stall  = 0;
      run("after_rst", 2'd0, 32'h20, 64'h0, 8'h00, 4'd3, 0, 1'b0, 1'b0,
          2'd2, 32'h20, 64'hDEADBEEFCAFEF00D, 1'b0);

      // Reset while a read response is pending in RESP.
      req_valid = 1'b1;
      req_type  = 2'd0;
      req_addr  = 32'h10;
      req_id    = 4'd5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk);
         #1;
         seen = rsp_valid;
      end
      chk("resp.valid_before_rst", 64'(seen), 64'(1'b1));
      reset_n = 1'b0;
      #1;
      chk_reset_vals("rst_resp");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         seen = seen | rsp_valid;
      end
      chk("resp.no_stray_rsp", 64'(seen), 64'(1'b0));
      ref_reads  = 0;
      ref_writes = 0;
      ref_stall  = 0;
      run("after_rst2", 2'd0, 32'h1FF8, 64'h0, 8'h00, 4'd9, 0, 1'b0,
          1'b0, 2'd2, 32'h1FF8, 64'h0123456789ABCDEF, 1'b0);

      // Random traffic over words 0..15 plus out-of-range and illegal.
      for (int w = 0; w < 16; w++) begin
         d = {$urandom, $urandom};
         model(2'd1, 32'(w * 8), d, 8'hFF, et, ea, ed, ee);
         run("init", 2'd1, 32'(w * 8), d, 8'hFF, 4'(w), 0, 1'b0, 1'b0,
             et, ea, ed, ee);
      end
      for (int n = 0; n < 200; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         t = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'(r - 6);
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h2000;
         else a = 32'($urandom_range(0, 127));
         d     = {$urandom, $urandom};
         be    = 8'($urandom);
         id    = 4'($urandom);
         stall = int'($urandom_range(0, 3));
         early = (stall == 0) && ($urandom_range(0, 1) == 1);
         junk  = ($urandom_range(0, 3) == 0);
         model(t, a, d, be, et, ea, ed, ee);
         run($sformatf("rnd%0d", n), t, a, d, be, id, stall, early, junk,
             et, ea, ed, ee);
      end
      chk_stats("final_stats");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
